// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback over a
// shared ALU and memory datapath, with memory-ready timeout and a retired-instruction counter.
module mips_multicycle_ctrl #(
    parameter int unsigned WAIT_LIMIT = 15,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             iord,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_we,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             illegal,
    output logic             retire,
    output logic [CNT_W-1:0] instr_cnt,
    output logic [3:0]       state
);

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        R_EXEC    = 4'd6,
        R_WB      = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
        I_EXEC    = 4'd10,
        I_WB      = 4'd11,
        TRAP      = 4'd12
    } state_t;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_ADDI = 6'h08;

    // Counter only has to reach WAIT_LIMIT-1; the next idle cycle traps instead of counting.
    localparam int unsigned WAIT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_LIMIT - 1);

    state_t            cur_state;
    state_t            nxt_state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              timed_out;

    // funct is decoded by the ALU control block, not by this sequencer.
    logic unused_funct;
    assign unused_funct = ^funct;

    assign timed_out = (WAIT_LIMIT != 0) && !mem_ready && (wait_cnt == WAIT_LAST);
    assign state     = cur_state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_state <= FETCH;
            wait_cnt  <= '0;
            instr_cnt <= '0;
        end else begin
            cur_state <= nxt_state;
            if (nxt_state != cur_state)
                wait_cnt <= '0;
            else if (!mem_ready)
                wait_cnt <= wait_cnt + 1'b1;
            if (retire)
                instr_cnt <= instr_cnt + 1'b1;
        end
    end

    always_comb begin
        nxt_state  = cur_state;
        iord       = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = 2'd0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_we     = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'd0;
        alu_op     = 2'd0;
        illegal    = 1'b0;
        retire     = 1'b0;
        unique case (cur_state)
            FETCH: begin
                mem_rd    = 1'b1;
                alu_src_b = 2'd1;
                if (mem_ready) begin
                    ir_we     = 1'b1;
                    pc_we     = 1'b1;
                    nxt_state = DECODE;
                end else if (timed_out) begin
                    nxt_state = TRAP;
                end
            end
            DECODE: begin
                alu_src_b = 2'd3;
                case (opcode)
                    OP_LW, OP_SW: nxt_state = MEM_ADDR;
                    OP_R:         nxt_state = R_EXEC;
                    OP_BEQ:       nxt_state = BRANCH;
                    OP_J:         nxt_state = JUMP;
                    OP_ADDI:      nxt_state = I_EXEC;
                    default:      nxt_state = TRAP;
                endcase
            end
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                nxt_state = (opcode == OP_SW) ? MEM_WRITE : MEM_READ;
            end
            MEM_READ: begin
                mem_rd = 1'b1;
                iord   = 1'b1;
                if (mem_ready)
                    nxt_state = MEM_WB;
                else if (timed_out)
                    nxt_state = TRAP;
            end
            MEM_WB: begin
                reg_we     = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                nxt_state  = FETCH;
            end
            MEM_WRITE: begin
                mem_wr = 1'b1;
                iord   = 1'b1;
                if (mem_ready) begin
                    retire    = 1'b1;
                    nxt_state = FETCH;
                end else if (timed_out) begin
                    nxt_state = TRAP;
                end
            end
            R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'd2;
                nxt_state = R_WB;
            end
            R_WB: begin
                reg_we    = 1'b1;
                reg_dst   = 1'b1;
                retire    = 1'b1;
                nxt_state = FETCH;
            end
            BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'd1;
                pc_src    = 2'd1;
                pc_we     = zero;
                retire    = 1'b1;
                nxt_state = FETCH;
            end
            JUMP: begin
                pc_src    = 2'd2;
                pc_we     = 1'b1;
                retire    = 1'b1;
                nxt_state = FETCH;
            end
            I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                nxt_state = I_WB;
            end
            I_WB: begin
                reg_we    = 1'b1;
                retire    = 1'b1;
                nxt_state = FETCH;
            end
            TRAP: begin
                illegal = 1'b1;
            end
            default: nxt_state = TRAP;
        endcase
    end

endmodule
